pacman_ctrl_arbiter: RTL
========================

# pacman_ctrl_arbiter

Round-robin arbiter that shares the 32-bit `control` PIO register slave among several hardware requesters, such as game-logic FSMs, the sprite engine and the debug port. It sits between the requesters and the PIO's Avalon-MM slave port. It serialises single-beat reads and writes, drives the slave's chipselect/write_n/address/writedata, and returns read data and a one-cycle acknowledge to the granted requester.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: data width; matches the PIO slave.
- `ADDR_W`, 2: slave address width.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req` in NUM_REQ: per-requester transaction request, level.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*ADDR_W: packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- `req_wdata` in NUM_REQ*DATA_W: packed write data.
- `ack` out NUM_REQ: one-cycle completion pulse, one-hot.
- `rdata` out DATA_W: read data, valid in the `ack` cycle.
- `busy` out 1: a transaction is in flight.
- `grant_id` out $clog2(NUM_REQ): index of the current or last granted requester.
- `avm_address` out ADDR_W: to the slave address.
- `avm_chipselect` out 1: to the slave chipselect.
- `avm_write_n` out 1: to the slave write_n, active-low.
- `avm_writedata` out DATA_W: to the slave writedata.
- `avm_readdata` in DATA_W: slave readdata; combinational from the slave, zero-wait.

## Operation
- FSM states: IDLE, ISSUE, ACK.
- IDLE:
  - If any `req` is high, pick the winner by round-robin, starting the search at `rr_ptr`.
  - Latch its write flag, address and wdata into internal registers.
  - Set `grant_id` and go to ISSUE.
- ISSUE, exactly one cycle:
  - `avm_chipselect`=1 and `avm_address`/`avm_writedata` come from the latched values.
  - `avm_write_n` = ~latched write flag.
  - On a read, capture `avm_readdata` into the `rdata` register at the end of the cycle.
  - Go to ACK.
- ACK, one cycle:
  - `ack[grant_id]`=1.
  - `rr_ptr` ← (grant_id+1) mod NUM_REQ.
  - Go to IDLE.
- Payload is latched at grant. A requester dropping `req` or changing its payload after the grant does not affect the transaction, and `ack` still pulses.
- A requester still holding `req` in the cycle after `ack` is treated as a new request. Round-robin forbids it from winning again while others are pending.
- `rdata` holds its value until the next read completes. Writes do not alter `rdata`.
- `busy` = (state != IDLE).
- Outside ISSUE: `avm_chipselect`=0, `avm_write_n`=1, and `avm_address`/`avm_writedata` hold their last values.

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0, `grant_id`=0.
  - `ack`=0, `rdata`=0, `busy`=0.
  - `avm_chipselect`=0, `avm_write_n`=1, `avm_address`=0, `avm_writedata`=0.
- Latency, with `req` sampled high at edge E0 in IDLE:
  - ISSUE runs from E0 to E1; the slave register updates at E1.
  - `ack` is high from E1 to E2.
  - The earliest next grant is at E2.
- Throughput: one transaction per 3 cycles.
- Simultaneous requests: the lowest index at or after `rr_ptr`, with wrap, wins.
- `req` arriving during ISSUE/ACK waits; it is not lost as long as it is held.
- Reset asserted mid-ISSUE or mid-ACK: the FSM aborts asynchronously, chipselect drops immediately, and no `ack` is emitted. The slave write is not performed unless it had already occurred at a prior edge.

## Configuration
- `PACMAN_CTRL_ARB_PRIO0_EN` defined:
  - Requester 0 (CPU-side) has fixed absolute priority. Whenever `req[0]` is high in IDLE it wins, regardless of `rr_ptr`.
  - A grant to requester 0 does not update `rr_ptr`.
  - Other requesters remain round-robin among themselves.
- Not defined: pure round-robin over all NUM_REQ requesters.

## Structure
- Package `pacman_ctrl_arb_pkg`:
  - State enum `arb_state_t` {IDLE, ISSUE, ACK}.
  - Localparams for the default widths and `NUM_REQ` bounds.
- Sub-module `pacman_rr_picker`:
  - Combinational rotating priority encoder.
  - Inputs: `req` vector and `rr_ptr`.
  - Outputs: `valid` and winner index.
  - The arbiter instantiates it once and keeps the FSM and registers.

## Test plan
- Single write: req[2]=1, write, addr 0, wdata 0xDEADBEEF.
  - Expect chipselect=1 and write_n=0 for exactly one cycle.
  - Expect the slave's out_port=0xDEADBEEF and ack[2] on the following cycle.
- Read-back after that write: req[1] read, addr 0 → rdata=0xDEADBEEF with ack[1]. A read at addr 1 returns 0.
- All four requesters held high from reset:
  - Grant order is 0,1,2,3,0.
  - Acks are spaced 3 cycles apart.
  - avm_writedata sequence matches each requester's wdata (0x10,0x11,0x12,0x13).
- With PACMAN_CTRL_ARB_PRIO0_EN, req[0] held continuously with req[3] also high:
  - Requester 0 wins every slot.
  - After req[0] drops, requester 3 is granted next.
- Requester 1 drops req one cycle after grant → the transaction completes, ack[1] pulses, and the slave is written.
- reset_n pulsed low during ISSUE:
  - chipselect falls asynchronously.
  - No ack is emitted.
  - After release, all outputs are at their reset values and a fresh request is served normally.

Source files
------------

// File: rtl/pacman_ctrl_arb_pkg.sv
// Shared types and constants for the PIO control-register arbiter.
// Build option: PACMAN_CTRL_ARB_PRIO0_EN (fixed priority for requester 0).
package pacman_ctrl_arb_pkg;

  localparam int ARB_NUM_REQ_DEF = 4;
  localparam int ARB_NUM_REQ_MIN = 2;
  localparam int ARB_NUM_REQ_MAX = 8;
  localparam int ARB_DATA_W_DEF  = 32;
  localparam int ARB_ADDR_W_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
    return ((id + 32'd1) >= n) ? 32'd0 : (id + 32'd1);
  endfunction

endpackage

// File: rtl/pacman_rr_picker.sv
// Combinational rotating priority encoder: the first set request at or
// after rr_ptr (with wrap) wins.
module pacman_rr_picker
  import pacman_ctrl_arb_pkg::*;
#(
  parameter  int NUM_REQ = ARB_NUM_REQ_DEF,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest offset down so the nearest hit to rr_ptr is kept last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    w_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx  = IDX_W'((32'(rr_ptr) + 32'(k)) % 32'(NUM_REQ));
      valid  = valid | req[w_idx];
      winner = req[w_idx] ? w_idx : winner;
    end
  end

endmodule

// File: rtl/pacman_ctrl_arbiter.sv
// Round-robin arbiter sharing the PIO control-register slave among
// several requesters. Single-beat transactions: IDLE -> ISSUE -> ACK.
// Build option: PACMAN_CTRL_ARB_PRIO0_EN gives requester 0 absolute
// priority and leaves the round-robin pointer untouched on its grants.
module pacman_ctrl_arbiter
  import pacman_ctrl_arb_pkg::*;
#(
  parameter  int NUM_REQ = ARB_NUM_REQ_DEF,
  parameter  int DATA_W  = ARB_DATA_W_DEF,
  parameter  int ADDR_W  = ARB_ADDR_W_DEF,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id,
  output logic [ADDR_W-1:0]         avm_address,
  output logic                      avm_chipselect,
  output logic                      avm_write_n,
  output logic [DATA_W-1:0]         avm_writedata,
  input  logic [DATA_W-1:0]         avm_readdata
);

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_grant_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_cs;
  logic                r_write_n;
  logic [NUM_REQ-1:0]  r_ack;
  logic [DATA_W-1:0]   r_rdata;

  logic [NUM_REQ-1:0]  w_pick_req;
  logic                w_rr_valid;
  logic [IDX_W-1:0]    w_rr_winner;
  logic                w_valid;
  logic [IDX_W-1:0]    w_winner;
  logic [IDX_W-1:0]    w_rr_next;
  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

`ifdef PACMAN_CTRL_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation; the others rotate among themselves.
  assign w_pick_req = {req[NUM_REQ-1:1], 1'b0};
  assign w_valid    = w_rr_valid | req[0];
  assign w_winner   = req[0] ? '0 : w_rr_winner;
  assign w_rr_next  = (r_grant_id == '0) ? r_rr_ptr
                                         : IDX_W'(rr_next(32'(r_grant_id), NUM_REQ));
`else
  assign w_pick_req = req;
  assign w_valid    = w_rr_valid;
  assign w_winner   = w_rr_winner;
  assign w_rr_next  = IDX_W'(rr_next(32'(r_grant_id), NUM_REQ));
`endif

  pacman_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (w_pick_req),
    .rr_ptr (r_rr_ptr),
    .valid  (w_rr_valid),
    .winner (w_rr_winner)
  );

  // Select the winning requester's payload from the packed input buses.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_write = (w_winner == IDX_W'(i)) ? req_write[i]                 : w_sel_write;
      w_sel_addr  = (w_winner == IDX_W'(i)) ? req_addr[i*ADDR_W +: ADDR_W] : w_sel_addr;
      w_sel_wdata = (w_winner == IDX_W'(i)) ? req_wdata[i*DATA_W +: DATA_W] : w_sel_wdata;
    end
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: ISSUE and ACK each last exactly one cycle.
  always_comb begin
    w_next_state = IDLE;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_next_state = ISSUE;
        end else begin
          w_next_state = IDLE;
        end
      end
      ISSUE:   w_next_state = ACK;
      ACK:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: latch payload at grant, drive the slave in ISSUE, ack afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cs       <= 1'b0;
      r_write_n  <= 1'b1;
      r_ack      <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= '0;
          if (w_valid) begin
            r_grant_id <= w_winner;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_cs       <= 1'b1;
            r_write_n  <= ~w_sel_write;
          end else begin
            r_cs       <= 1'b0;
            r_write_n  <= 1'b1;
          end
        end
        ISSUE: begin
          r_cs      <= 1'b0;
          r_write_n <= 1'b1;
          r_ack     <= NUM_REQ'(1) << r_grant_id;
          if (r_write_n) begin
            r_rdata <= avm_readdata;
          end else begin
            r_rdata <= r_rdata;
          end
        end
        ACK: begin
          r_ack    <= '0;
          r_rr_ptr <= w_rr_next;
        end
        default: begin
          r_ack     <= '0;
          r_cs      <= 1'b0;
          r_write_n <= 1'b1;
        end
      endcase
    end
  end

  assign ack            = r_ack;
  assign rdata          = r_rdata;
  assign busy           = (r_state != IDLE);
  assign grant_id       = r_grant_id;
  assign avm_address    = r_addr;
  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_write_n;
  assign avm_writedata  = r_wdata;

endmodule
